lcd_fetch: RTL

LCD_FETCH -- requirements
Module: lcd_fetch

---
 rtl/lcd_fetch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lcd_fetch.sv
// rtl/lcd_fetch.sv - copies a 640x64 1-bpp bitmap from memory into the nibble framebuffer; optional frame_done via LCD_FETCH_DONE_IRQ_EN
module lcd_fetch (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        lcdon,
  input  logic        frame_start,
  input  logic [20:0] base,
  output logic        mem_req,
  output logic [20:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_di,
  output logic        vram_we,
  output logic [13:0] vram_wa,
  output logic [3:0]  vram_do,
  output logic        busy
`ifdef LCD_FETCH_DONE_IRQ_EN
  ,
  output logic        frame_done
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WR_HI, WR_LO} state_t;

  state_t      state_q, state_d;
  logic [20:0] base_q, base_d;
  logic [5:0]  line_q, line_d;
  logic [6:0]  col_q, col_d;
  logic [3:0]  lo_q, lo_d;
  logic        mem_req_q, mem_req_d;
  logic [20:0] mem_addr_q, mem_addr_d;
  logic        vram_we_q, vram_we_d;
  logic [13:0] vram_wa_q, vram_wa_d;
  logic [3:0]  vram_do_q, vram_do_d;
  logic        busy_q, busy_d;
`ifdef LCD_FETCH_DONE_IRQ_EN
  logic        done_q, done_d;
`endif

  // Position of the byte following the current one, and its memory address.
  logic        col_last, line_last;
  logic [6:0]  col_nx;
  logic [5:0]  line_nx;
  logic [20:0] next_addr;

  assign col_last  = (col_q == 7'd79);
  assign line_last = (line_q == 6'd63);
  assign col_nx    = col_last ? 7'd0 : col_q + 7'd1;
  assign line_nx   = col_last ? line_q + 6'd1 : line_q;
  // line*80 = line*64 + line*16; the sum wraps at 2^21 by construction
  assign next_addr = base_q + {9'd0, line_nx, 6'd0} + {11'd0, line_nx, 4'd0} + {14'd0, col_nx};

  // Next-state and registered-output computation for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    line_d     = line_q;
    col_d      = col_q;
    lo_d       = lo_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    vram_we_d  = 1'b0;
    vram_wa_d  = vram_wa_q;
    vram_do_d  = vram_do_q;
    busy_d     = busy_q;
`ifdef LCD_FETCH_DONE_IRQ_EN
    done_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          base_d     = base;
          line_d     = 6'd0;
          col_d      = 7'd0;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = base;
          state_d    = REQ;
        end
      end
      REQ: begin
        // mem_req is always high in this state, so only here is an ack honoured
        if (mem_ack) begin
          lo_d       = mem_di[3:0];
          mem_req_d  = 1'b0;
          vram_we_d  = 1'b1;
          vram_wa_d  = {line_q, col_q, 1'b0};
          vram_do_d  = mem_di[7:4];
          state_d    = WR_HI;
        end
      end
      WR_HI: begin
        vram_we_d = 1'b1;
        vram_wa_d = {line_q, col_q, 1'b1};
        vram_do_d = lo_q;
        state_d   = WR_LO;
      end
      default: begin
        line_d = line_nx;
        col_d  = col_nx;
        if (col_last && line_last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef LCD_FETCH_DONE_IRQ_EN
          done_d  = 1'b1;
`endif
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = next_addr;
          state_d    = REQ;
        end
      end
    endcase
    // Display off abandons everything; framebuffer keeps what was written.
    if (!lcdon) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      vram_we_d = 1'b0;
      busy_d    = 1'b0;
`ifdef LCD_FETCH_DONE_IRQ_EN
      done_d    = 1'b0;
`endif
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= 21'd0;
      line_q     <= 6'd0;
      col_q      <= 7'd0;
      lo_q       <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 21'd0;
      vram_we_q  <= 1'b0;
      vram_wa_q  <= 14'd0;
      vram_do_q  <= 4'd0;
      busy_q     <= 1'b0;
`ifdef LCD_FETCH_DONE_IRQ_EN
      done_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      line_q     <= line_d;
      col_q      <= col_d;
      lo_q       <= lo_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      vram_we_q  <= vram_we_d;
      vram_wa_q  <= vram_wa_d;
      vram_do_q  <= vram_do_d;
      busy_q     <= busy_d;
`ifdef LCD_FETCH_DONE_IRQ_EN
      done_q     <= done_d;
`endif
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign vram_we  = vram_we_q;
  assign vram_wa  = vram_wa_q;
  assign vram_do  = vram_do_q;
  assign busy     = busy_q;
`ifdef LCD_FETCH_DONE_IRQ_EN
  assign frame_done = done_q;
`endif

endmodule
